// File: rtl/ps2_codes_pkg.sv
// Scan codes, state encodings and shared types for the PS/2 direction-key transmitter.
package ps2_codes_pkg;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned NUM_KEYS   = 4;

  typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} enc_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_FRAME, TX_GAP} tx_state_t;

  // Pending event chosen by the arbiter: key index (0=left..3=down) and make/break.
  typedef struct packed {
    logic       brk;
    logic [1:0] key;
  } sel_t;

  function automatic logic [7:0] scan_code(input logic [1:0] key);
    case (key)
      2'd0:    scan_code = SC_LEFT;
      2'd1:    scan_code = SC_RIGHT;
      2'd2:    scan_code = SC_UP;
      default: scan_code = SC_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_encoder_if.sv
// Key levels in, PS/2 lines and transmit status out.
interface ps2_dir_encoder_if;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       busy;
  logic [7:0] tx_byte;
  logic       byte_done;

  modport master (
    input  left, right, up, down,
    output ps2_clk_o, ps2_data_o, busy, tx_byte, byte_done
  );

  modport slave (
    output left, right, up, down,
    input  ps2_clk_o, ps2_data_o, busy, tx_byte, byte_done
  );
endinterface

// File: rtl/ps2_frame_tx.sv
// Serialises one byte as an 11-bit device-to-host PS/2 frame, then holds both lines high for the gap.
module ps2_frame_tx
  import ps2_codes_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2000,
  parameter int unsigned GAP_HALVES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       byte_done,
  output logic       gap_done_c
);
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_HALVES - 1);

  tx_state_t              st, st_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [BIT_W-1:0]       bit_idx, bit_n;
  logic [GAP_W-1:0]       ghalf, ghalf_n;
  logic                   lo, lo_n;
  logic [FRAME_BITS-2:0]  shreg, shreg_n;
  logic                   clk_n, data_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= TX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      ghalf     <= '0;
      lo        <= 1'b0;
      shreg     <= '0;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      ghalf     <= ghalf_n;
      lo        <= lo_n;
      shreg     <= shreg_n;
      ps2_clk   <= clk_n;
      ps2_data  <= data_n;
      byte_done <= done_n;
    end
  end

  // shreg holds data[0..7], parity, stop; the start bit is driven directly on entry.
  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    ghalf_n    = ghalf;
    lo_n       = lo;
    shreg_n    = shreg;
    clk_n      = ps2_clk;
    data_n     = ps2_data;
    done_n     = 1'b0;
    gap_done_c = 1'b0;
    case (st)
      TX_IDLE: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (start) begin
          st_n    = TX_FRAME;
          shreg_n = {1'b1, ~^data, data};
          data_n  = 1'b0;
          cnt_n   = '0;
          bit_n   = '0;
          lo_n    = 1'b0;
        end
      end
      TX_FRAME: begin
        // Registered pulse lands on the final cycle of the stop bit's low half.
        done_n = lo && (bit_idx == BIT_LAST) && (cnt == CNT_PENULT);
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (!lo) begin
            lo_n  = 1'b1;
            clk_n = 1'b0;
          end else if (bit_idx == BIT_LAST) begin
            st_n    = TX_GAP;
            lo_n    = 1'b0;
            ghalf_n = '0;
            clk_n   = 1'b1;
            data_n  = 1'b1;
          end else begin
            lo_n    = 1'b0;
            bit_n   = bit_idx + 1'b1;
            clk_n   = 1'b1;
            data_n  = shreg[0];
            shreg_n = shreg >> 1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_GAP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (ghalf == GAP_LAST) begin
            gap_done_c = 1'b1;
            st_n       = TX_IDLE;
          end else begin
            ghalf_n = ghalf + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: st_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_dir_encoder.sv
// Direction keys to PS/2 make/break bytes: edge detection, pend flags, arbitration and break sequencing.
module ps2_dir_encoder
  import ps2_codes_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2000,
  parameter int unsigned GAP_HALVES = 4
) (
  input logic               clk,
  input logic               rst,
  ps2_dir_encoder_if.master bus
);
  logic [NUM_KEYS-1:0] keys, prev, make_pend, brk_pend, mp_n, bp_n;
  logic [NUM_KEYS-1:0] rise, fall, cancel, sel_mask, load_make, load_brk;
  enc_state_t          state, state_n;
  sel_t                sel, sel_n;
  logic                sec_due, sec_due_n, busy_r, busy_n;
  logic [7:0]          sec_code, sec_code_n, tx_byte_r, tx_byte_n;
  logic                start_c, frame_done, gap_done_c;

  // Lowest key index wins; make beats break within a key.
  function automatic sel_t pick(input logic [NUM_KEYS-1:0] mp, input logic [NUM_KEYS-1:0] bp);
    sel_t s;
    s = '0;
    if (mp[0] | bp[0])      begin s.key = 2'd0; s.brk = ~mp[0]; end
    else if (mp[1] | bp[1]) begin s.key = 2'd1; s.brk = ~mp[1]; end
    else if (mp[2] | bp[2]) begin s.key = 2'd2; s.brk = ~mp[2]; end
    else                    begin s.key = 2'd3; s.brk = ~mp[3]; end
    return s;
  endfunction

  assign keys     = {bus.down, bus.up, bus.right, bus.left};
  assign rise     = keys & ~prev;
  assign fall     = ~keys & prev;
  assign sel_mask = NUM_KEYS'(1) << sel.key;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prev      <= '0;
      make_pend <= '0;
      brk_pend  <= '0;
      sel       <= '0;
      sec_due   <= 1'b0;
      sec_code  <= '0;
      tx_byte_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= keys;
      make_pend <= mp_n;
      brk_pend  <= bp_n;
      sel       <= sel_n;
      sec_due   <= sec_due_n;
      sec_code  <= sec_code_n;
      tx_byte_r <= tx_byte_n;
      busy_r    <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    sec_due_n  = sec_due;
    sec_code_n = sec_code;
    tx_byte_n  = tx_byte_r;
    start_c    = 1'b0;
    load_make  = '0;
    load_brk   = '0;
    case (state)
      IDLE: begin
        if (|(make_pend | brk_pend)) begin
          sel_n   = pick(make_pend, brk_pend);
          state_n = LOAD;
        end
      end
      LOAD: begin
        start_c = 1'b1;
        state_n = FRAME;
        if (sec_due) begin
          tx_byte_n = sec_code;
          sec_due_n = 1'b0;
        end else if (sel.brk) begin
          tx_byte_n  = SC_BREAK;
          sec_code_n = scan_code(sel.key);
          sec_due_n  = 1'b1;
          load_brk   = sel_mask;
        end else begin
          tx_byte_n = scan_code(sel.key);
          load_make = sel_mask;
        end
      end
      FRAME: if (frame_done) state_n = GAP;
      GAP:   if (gap_done_c) state_n = sec_due ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase

    // A release cancels a make that has not started; a make being loaded this cycle counts as started.
    cancel = fall & make_pend & ~load_make;
    mp_n   = ((make_pend & ~load_make) | rise) & ~cancel;
    bp_n   = (brk_pend & ~load_brk & ~rise) | (fall & ~cancel);

    busy_n = (state_n == FRAME) || (state_n == GAP) || ((state == GAP) && (state_n == LOAD));
  end

  ps2_frame_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_HALVES (GAP_HALVES)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .start      (start_c),
    .data       (tx_byte_n),
    .ps2_clk    (bus.ps2_clk_o),
    .ps2_data   (bus.ps2_data_o),
    .byte_done  (frame_done),
    .gap_done_c (gap_done_c)
  );

  assign bus.byte_done = frame_done;
  assign bus.busy      = busy_r;
  assign bus.tx_byte   = tx_byte_r;

endmodule

// File: tb/tb_ps2_dir_encoder.sv
// Scoreboard bench: stimulus queues expected bytes, a PS/2 line monitor decodes frames and compares.
module tb_ps2_dir_encoder;
  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_HALVES = 4;
  localparam int FRAME_CYC = 88;
  localparam int GAP_CYC   = 16;

  typedef struct packed {
    logic [7:0] b;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  ps2_dir_encoder_if bus();

  ps2_dir_encoder #(
    .CLK_DIV    (CLK_DIV),
    .GAP_HALVES (GAP_HALVES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         drop_cnt = 0;
  logic [3:0] dir = 4'b0000;

  logic [7:0] codes [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
  logic       pars  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Line monitor: decodes frames on ps2 clock falling edges and runs the scoreboard.
  logic        prev_pclk = 1'b1;
  logic        prev_busy = 1'b0;
  logic        busy_hold = 1'b0;
  logic        in_frame = 1'b0;
  logic        brk_seen = 1'b0;
  int          nbits = 0;
  int          start_cyc = 0;
  int          last_done = -1000;
  logic [10:0] fr = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      nbits = 0; in_frame = 1'b0; prev_pclk = 1'b1; prev_busy = 1'b0;
      busy_hold = 1'b0; last_done = -1000;
    end else begin
      if (!in_frame && bus.ps2_data_o === 1'b0) begin
        in_frame  = 1'b1;
        start_cyc = cyc;
        check("busy_at_start", 32'(bus.busy), 1);
        if (busy_hold) check("gap_to_next_start", cyc - last_done, GAP_CYC + 2);
      end
      if (prev_pclk && bus.ps2_clk_o === 1'b0 && in_frame) begin
        if (nbits < 11) fr[nbits] = bus.ps2_data_o;
        nbits++;
      end
      if (bus.byte_done === 1'b1) begin
        done_cnt++;
        check("frame_len", cyc - start_cyc + 1, FRAME_CYC);
        check("bit_count", nbits, 11);
        check("start_bit", 32'(fr[0]), 0);
        check("stop_bit", 32'(fr[10]), 1);
        check("exp_available", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte", 32'(fr[8:1]), 32'(e.b));
          check("parity", 32'(fr[9]), 32'(e.p));
          check("tx_byte", 32'(bus.tx_byte), 32'(e.b));
        end
        if (fr[8:1] == 8'hF0) brk_seen = 1'b1;
        else begin
          case (fr[8:1])
            8'h6B: dir[0] = ~brk_seen;
            8'h74: dir[1] = ~brk_seen;
            8'h75: dir[2] = ~brk_seen;
            8'h72: dir[3] = ~brk_seen;
            default: ;
          endcase
          brk_seen = 1'b0;
        end
        in_frame = 1'b0; nbits = 0; last_done = cyc; busy_hold = 1'b1;
      end
      if (prev_busy && bus.busy === 1'b0) begin
        drop_cnt++;
        check("gap_len", cyc - last_done, GAP_CYC + 1);
        busy_hold = 1'b0;
      end
      prev_busy = bus.busy;
      prev_pclk = bus.ps2_clk_o;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_keys(input logic [3:0] k);
    @(posedge clk);
    #1 {bus.down, bus.up, bus.right, bus.left} = k;
  endtask

  task automatic push(input logic [7:0] b, input logic p);
    exp_t e;
    e.b = b;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 20 && n < 4000) begin
      @(negedge clk);
      n++;
      quiet = (bus.busy === 1'b0) ? quiet + 1 : 0;
    end
    check({name, "_timeout"}, 32'(n < 4000), 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, b0;
    {bus.down, bus.up, bus.right, bus.left} = 4'b0000;
    rst = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_ps2_clk", 32'(bus.ps2_clk_o), 1);
    check("rst_ps2_data", 32'(bus.ps2_data_o), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_byte_done", 32'(bus.byte_done), 0);
    check("rst_tx_byte", 32'(bus.tx_byte), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Left make
    d0 = done_cnt; b0 = drop_cnt;
    push(8'h6B, 1'b0);
    set_keys(4'b0001);
    wait_quiet("t1");
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_busy_drops", drop_cnt - b0, 1);

    // Left break: F0 then 6B with busy held across the pair
    d0 = done_cnt; b0 = drop_cnt;
    push(8'hF0, 1'b1); push(8'h6B, 1'b0);
    set_keys(4'b0000);
    wait_quiet("t2");
    check("t2_done_pulses", done_cnt - d0, 2);
    check("t2_busy_drops", drop_cnt - b0, 1);

    // Simultaneous right/up/down makes, then simultaneous breaks
    d0 = done_cnt;
    push(8'h74, 1'b1); push(8'h75, 1'b0); push(8'h72, 1'b1);
    set_keys(4'b1110);
    wait_quiet("t3");
    check("t3_done_pulses", done_cnt - d0, 3);
    push(8'hF0, 1'b1); push(8'h74, 1'b1);
    push(8'hF0, 1'b1); push(8'h75, 1'b0);
    push(8'hF0, 1'b1); push(8'h72, 1'b1);
    set_keys(4'b0000);
    wait_quiet("t3_rel");

    // Down glitch during left's break is suppressed
    push(8'h6B, 1'b0);
    set_keys(4'b0001);
    wait_quiet("t4_press");
    d0 = done_cnt;
    push(8'hF0, 1'b1); push(8'h6B, 1'b0);
    set_keys(4'b0000);
    step(20);
    set_keys(4'b1000);
    step(20);
    set_keys(4'b0000);
    wait_quiet("t4");
    check("t4_done_pulses", done_cnt - d0, 2);

    // Reset during bit 5 of up's make; up still held at release gives a fresh make
    set_keys(4'b0100);
    step(45);
    @(posedge clk);
    #1 check("t5_bit_at_reset", nbits, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_ps2_clk", 32'(bus.ps2_clk_o), 1);
    check("t5_ps2_data", 32'(bus.ps2_data_o), 1);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_tx_byte", 32'(bus.tx_byte), 0);
    push(8'h75, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_quiet("t5");
    push(8'hF0, 1'b1); push(8'h75, 1'b0);
    set_keys(4'b0000);
    wait_quiet("t5_rel");

    // Loopback direction decode: each press sets its direction, release clears it
    for (int k = 0; k < 4; k++) begin
      push(codes[k], pars[k]);
      set_keys(4'(1) << k);
      wait_quiet("t6_press");
      check("t6_dir_press", 32'(dir), 32'(4'(1) << k));
      push(8'hF0, 1'b1); push(codes[k], pars[k]);
      set_keys(4'b0000);
      wait_quiet("t6_release");
      check("t6_dir_release", 32'(dir), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
